rv_seq_ctrl: RTL and testbench

Multi-cycle sequencer for the single-bus RV32I datapath. It drives the 17-bit enable vector, RAM strobes and address-register load so that exactly one source owns the shared databus each cycle. It steps fetch, decode and execute for R-type, I-type ALU, load and store, and stalls on the RAM read latency. It sits between the instruction register (opcode in) and the datapath/RAM control inputs.

---
 rtl/rv_seq_pkg.sv | 70 +++++++
 rtl/rv_seq_perf.sv | 35 +++
 rtl/rv_seq_ctrl.sv | 177 +++++++++++++++++
 tb/tb_rv_seq_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_seq_pkg.sv
// Shared types and constants for the RV32I single-bus sequencer.
// The state encoding, en_sig bit positions, opcodes and register-file address selects live here.
package rv_seq_pkg;

  // state | meaning
  // IDLE  | parked, all outputs 0
  // F0..F3 | fetch; FW waits on RAM read latency
  // DEC   | opcode branch
  // Ax/Ix/Lx/Sx | R-type / I-type ALU / load / store execute; LW waits on RAM
  // ILL   | unsupported opcode, exits only on reset
  typedef enum logic [4:0] {
    ST_IDLE = 5'd0,
    ST_F0   = 5'd1,
    ST_F1   = 5'd2,
    ST_FW   = 5'd3,
    ST_F2   = 5'd4,
    ST_F3   = 5'd5,
    ST_DEC  = 5'd6,
    ST_A0   = 5'd7,
    ST_A1   = 5'd8,
    ST_A2   = 5'd9,
    ST_I0   = 5'd10,
    ST_I1   = 5'd11,
    ST_I2   = 5'd12,
    ST_L0   = 5'd13,
    ST_L1   = 5'd14,
    ST_L2   = 5'd15,
    ST_L3   = 5'd16,
    ST_LW   = 5'd17,
    ST_L4   = 5'd18,
    ST_S0   = 5'd19,
    ST_S1   = 5'd20,
    ST_S2   = 5'd21,
    ST_S3   = 5'd22,
    ST_ILL  = 5'd23
  } state_e;

  typedef enum logic [1:0] {
    RF_X0  = 2'd0,
    RF_RD  = 2'd1,
    RF_RS1 = 2'd2,
    RF_RS2 = 2'd3
  } rf_sel_e;

  localparam int EN_W          = 17;
  localparam int EN_PC_BUS     = 16;
  localparam int EN_ALU_BUS    = 15;
  localparam int EN_IMM_BUS    = 14;
  localparam int EN_RF_BUS     = 13;
  localparam int EN_RD_BUS     = 12;
  localparam int EN_PC         = 11;
  localparam int EN_A          = 10;
  localparam int EN_B          = 9;
  localparam int EN_IR         = 8;
  localparam int EN_RF_WEN     = 7;
  localparam int EN_RF_REN     = 6;
  localparam int EN_ALU_B4     = 5;
  localparam int EN_RF_SEL_LSB = 1;
  localparam int EN_ALU_FUNC   = 0;

  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  function automatic logic is_final(input state_e s);
    return (s == ST_A2) || (s == ST_I2) || (s == ST_L4) || (s == ST_S3);
  endfunction

endpackage

// File: rtl/rv_seq_perf.sv
// Busy-cycle and retire counters for the sequencer; both wrap modulo 2^32.
// Instantiated by rv_seq_ctrl only when RV_SEQ_PERF_EN is defined.
module rv_seq_perf
  import rv_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        busy_i,
  input  logic        retire_i,
  output logic [31:0] cycle_cnt_o,
  output logic [31:0] retire_cnt_o
);

  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;

  always_comb begin
    cycle_cnt_d  = busy_i   ? cycle_cnt_q + 32'd1  : cycle_cnt_q;
    retire_cnt_d = retire_i ? retire_cnt_q + 32'd1 : retire_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      cycle_cnt_q  <= cycle_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign cycle_cnt_o  = cycle_cnt_q;
  assign retire_cnt_o = retire_cnt_q;

endmodule

// File: rtl/rv_seq_ctrl.sv
// Moore sequencer for the single-bus RV32I datapath: fetch, decode, execute R/I/load/store.
// Optional RV_SEQ_PERF_EN adds cycle_cnt_o / retire_cnt_o performance counters.
module rv_seq_ctrl
  import rv_seq_pkg::*;
#(
  parameter int unsigned RAM_RD_LAT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run_i,
  input  logic [6:0]      opcode_i,
  output logic [EN_W-1:0] en_sig_o,
  output logic            mar_en_o,
  output logic            ram_ren_o,
  output logic            ram_wen_o,
  output logic            busy_o,
  output logic            illegal_o
`ifdef RV_SEQ_PERF_EN
  ,
  output logic [31:0]     cycle_cnt_o,
  output logic [31:0]     retire_cnt_o
`endif
);

  // Wait states hold RAM_RD_LAT-1 cycles; the counter loads the remaining count minus one.
  localparam int unsigned WAIT_N      = (RAM_RD_LAT > 1) ? RAM_RD_LAT - 2 : 0;
  localparam logic [2:0]  WAIT_RELOAD = 3'(WAIT_N);
  localparam bit          HAS_WAIT    = (RAM_RD_LAT > 1);

  state_e     state_q, state_d;
  logic [2:0] wait_q, wait_d;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      ST_IDLE: if (run_i) state_d = ST_F0;
      ST_F0:   state_d = ST_F1;
      ST_F1: begin
        if (HAS_WAIT) begin
          state_d = ST_FW;
          wait_d  = WAIT_RELOAD;
        end else begin
          state_d = ST_F2;
        end
      end
      ST_FW: begin
        if (wait_q == 3'd0) state_d = ST_F2;
        else                wait_d  = wait_q - 3'd1;
      end
      ST_F2:   state_d = ST_F3;
      ST_F3:   state_d = ST_DEC;
      ST_DEC: begin
        case (opcode_i)
          OP_R_TYPE: state_d = ST_A0;
          OP_I_ALU:  state_d = ST_I0;
          OP_LOAD:   state_d = ST_L0;
          OP_STORE:  state_d = ST_S0;
          default:   state_d = ST_ILL;
        endcase
      end
      ST_A0:   state_d = ST_A1;
      ST_A1:   state_d = ST_A2;
      ST_I0:   state_d = ST_I1;
      ST_I1:   state_d = ST_I2;
      ST_L0:   state_d = ST_L1;
      ST_L1:   state_d = ST_L2;
      ST_L2:   state_d = ST_L3;
      ST_L3: begin
        if (HAS_WAIT) begin
          state_d = ST_LW;
          wait_d  = WAIT_RELOAD;
        end else begin
          state_d = ST_L4;
        end
      end
      ST_LW: begin
        if (wait_q == 3'd0) state_d = ST_L4;
        else                wait_d  = wait_q - 3'd1;
      end
      ST_S0:   state_d = ST_S1;
      ST_S1:   state_d = ST_S2;
      ST_S2:   state_d = ST_S3;
      ST_A2, ST_I2, ST_L4, ST_S3: state_d = run_i ? ST_F0 : ST_IDLE;
      ST_ILL:  state_d = ST_ILL;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wait_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Outputs depend on state_q only, so reset clears them without waiting for a clock.
  always_comb begin
    en_sig_o  = '0;
    mar_en_o  = 1'b0;
    ram_ren_o = 1'b0;
    ram_wen_o = 1'b0;
    case (state_q)
      ST_F0: begin
        en_sig_o[EN_PC_BUS] = 1'b1;
        en_sig_o[EN_A]      = 1'b1;
        mar_en_o            = 1'b1;
      end
      ST_F1, ST_L3: ram_ren_o = 1'b1;
      ST_F2: begin
        en_sig_o[EN_RD_BUS] = 1'b1;
        en_sig_o[EN_IR]     = 1'b1;
      end
      ST_F3: begin
        en_sig_o[EN_ALU_BUS] = 1'b1;
        en_sig_o[EN_ALU_B4]  = 1'b1;
        en_sig_o[EN_PC]      = 1'b1;
      end
      ST_A0, ST_I0, ST_L0, ST_S0: begin
        en_sig_o[EN_RF_REN]                 = 1'b1;
        en_sig_o[EN_RF_SEL_LSB +: 2]        = RF_RS1;
        en_sig_o[EN_RF_BUS]                 = 1'b1;
        en_sig_o[EN_A]                      = 1'b1;
      end
      ST_A1: begin
        en_sig_o[EN_RF_REN]                 = 1'b1;
        en_sig_o[EN_RF_SEL_LSB +: 2]        = RF_RS2;
        en_sig_o[EN_RF_BUS]                 = 1'b1;
        en_sig_o[EN_B]                      = 1'b1;
      end
      ST_I1, ST_L1, ST_S1: begin
        en_sig_o[EN_IMM_BUS] = 1'b1;
        en_sig_o[EN_B]       = 1'b1;
      end
      ST_A2, ST_I2: begin
        en_sig_o[EN_ALU_BUS]                = 1'b1;
        en_sig_o[EN_ALU_FUNC]               = 1'b1;
        en_sig_o[EN_RF_WEN]                 = 1'b1;
        en_sig_o[EN_RF_SEL_LSB +: 2]        = RF_RD;
      end
      ST_L2, ST_S2: begin
        en_sig_o[EN_ALU_BUS] = 1'b1;
        mar_en_o             = 1'b1;
      end
      ST_L4: begin
        en_sig_o[EN_RD_BUS]                 = 1'b1;
        en_sig_o[EN_RF_WEN]                 = 1'b1;
        en_sig_o[EN_RF_SEL_LSB +: 2]        = RF_RD;
      end
      ST_S3: begin
        en_sig_o[EN_RF_REN]                 = 1'b1;
        en_sig_o[EN_RF_SEL_LSB +: 2]        = RF_RS2;
        en_sig_o[EN_RF_BUS]                 = 1'b1;
        ram_wen_o                           = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy_o    = (state_q != ST_IDLE) && (state_q != ST_ILL);
  assign illegal_o = (state_q == ST_ILL);

`ifdef RV_SEQ_PERF_EN
  rv_seq_perf u_perf (
    .clk          (clk),
    .rst_n        (rst_n),
    .busy_i       (busy_o),
    .retire_i     (is_final(state_q)),
    .cycle_cnt_o  (cycle_cnt_o),
    .retire_cnt_o (retire_cnt_o)
  );
`endif

endmodule

// File: tb/tb_rv_seq_ctrl.sv
// Bench for rv_seq_ctrl: three instances (RAM_RD_LAT 1/2/3) against a per-instruction output-sequence model.
// Define RV_SEQ_PERF_EN to also check the performance counters.
module tb_rv_seq_ctrl;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;

  logic        clk;
  logic        rst_n;
  logic        run   [3];
  logic [6:0]  opc   [3];
  logic [16:0] en_w  [3];
  logic        mar_w [3];
  logic        ren_w [3];
  logic        wen_w [3];
  logic        busy_w[3];
  logic        ill_w [3];
`ifdef RV_SEQ_PERF_EN
  logic [31:0] cyc_w [3];
  logic [31:0] ret_w [3];
`endif

  int lats[3] = '{1, 2, 3};
  int n_chk = 0;
  int n_err = 0;
  logic [20:0] exp_q[$];

  rv_seq_ctrl #(.RAM_RD_LAT(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .run_i(run[0]), .opcode_i(opc[0]),
    .en_sig_o(en_w[0]), .mar_en_o(mar_w[0]), .ram_ren_o(ren_w[0]), .ram_wen_o(wen_w[0]),
    .busy_o(busy_w[0]), .illegal_o(ill_w[0])
`ifdef RV_SEQ_PERF_EN
    , .cycle_cnt_o(cyc_w[0]), .retire_cnt_o(ret_w[0])
`endif
  );

  rv_seq_ctrl #(.RAM_RD_LAT(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .run_i(run[1]), .opcode_i(opc[1]),
    .en_sig_o(en_w[1]), .mar_en_o(mar_w[1]), .ram_ren_o(ren_w[1]), .ram_wen_o(wen_w[1]),
    .busy_o(busy_w[1]), .illegal_o(ill_w[1])
`ifdef RV_SEQ_PERF_EN
    , .cycle_cnt_o(cyc_w[1]), .retire_cnt_o(ret_w[1])
`endif
  );

  rv_seq_ctrl #(.RAM_RD_LAT(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .run_i(run[2]), .opcode_i(opc[2]),
    .en_sig_o(en_w[2]), .mar_en_o(mar_w[2]), .ram_ren_o(ren_w[2]), .ram_wen_o(wen_w[2]),
    .busy_o(busy_w[2]), .illegal_o(ill_w[2])
`ifdef RV_SEQ_PERF_EN
    , .cycle_cnt_o(cyc_w[2]), .retire_cnt_o(ret_w[2])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [16:0] b(input int i);
    return 17'(1) << i;
  endfunction

  function automatic logic [16:0] sel(input int s);
    return 17'(s) << 1;
  endfunction

  function automatic logic [20:0] ov(input logic busy, input logic wen, input logic ren,
                                     input logic mar, input logic [16:0] en);
    return {busy, wen, ren, mar, en};
  endfunction

  function automatic logic [20:0] obs(input int d);
    return {busy_w[d], wen_w[d], ren_w[d], mar_w[d], en_w[d]};
  endfunction

  // Expected per-cycle outputs for one instruction, written from the bus-ownership rules.
  task automatic build(input int lat, input logic [6:0] op);
    logic [16:0] rd_rs1, rd_rs2_b, imm_b, alu_wb;
    rd_rs1   = b(6) | sel(2) | b(13) | b(10);
    rd_rs2_b = b(6) | sel(3) | b(13) | b(9);
    imm_b    = b(14) | b(9);
    alu_wb   = b(15) | b(0) | b(7) | sel(1);
    exp_q.delete();
    exp_q.push_back(ov(1, 0, 0, 1, b(16) | b(10)));
    exp_q.push_back(ov(1, 0, 1, 0, '0));
    for (int k = 1; k < lat; k++) exp_q.push_back(ov(1, 0, 0, 0, '0));
    exp_q.push_back(ov(1, 0, 0, 0, b(12) | b(8)));
    exp_q.push_back(ov(1, 0, 0, 0, b(15) | b(5) | b(11)));
    exp_q.push_back(ov(1, 0, 0, 0, '0));
    if (op == OP_R) begin
      exp_q.push_back(ov(1, 0, 0, 0, rd_rs1));
      exp_q.push_back(ov(1, 0, 0, 0, rd_rs2_b));
      exp_q.push_back(ov(1, 0, 0, 0, alu_wb));
    end else if (op == OP_I) begin
      exp_q.push_back(ov(1, 0, 0, 0, rd_rs1));
      exp_q.push_back(ov(1, 0, 0, 0, imm_b));
      exp_q.push_back(ov(1, 0, 0, 0, alu_wb));
    end else if (op == OP_L) begin
      exp_q.push_back(ov(1, 0, 0, 0, rd_rs1));
      exp_q.push_back(ov(1, 0, 0, 0, imm_b));
      exp_q.push_back(ov(1, 0, 0, 1, b(15)));
      exp_q.push_back(ov(1, 0, 1, 0, '0));
      for (int k = 1; k < lat; k++) exp_q.push_back(ov(1, 0, 0, 0, '0));
      exp_q.push_back(ov(1, 0, 0, 0, b(12) | b(7) | sel(1)));
    end else if (op == OP_S) begin
      exp_q.push_back(ov(1, 0, 0, 0, rd_rs1));
      exp_q.push_back(ov(1, 0, 0, 0, imm_b));
      exp_q.push_back(ov(1, 0, 0, 1, b(15)));
      exp_q.push_back(ov(1, 1, 0, 0, b(6) | sel(3) | b(13)));
    end
  endtask

  // run is randomised mid-instruction (must be ignored) and set for the next boundary at the last cycle.
  task automatic exec(input int d, input logic [6:0] op, input bit last, input int stop_at);
    int n;
    build(lats[d], op);
    opc[d] = op;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check($sformatf("seq d%0d op%02h c%0d", d, op, i), 32'(obs(d)), 32'(exp_q[i]));
      check($sformatf("illegal d%0d c%0d", d, i), 32'(ill_w[d]), 32'd0);
      if (i == stop_at) return;
      if (i == n - 1) run[d] = !last;
      else            run[d] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic idle(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check($sformatf("idle d%0d", d), 32'(obs(d)), 32'd0);
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst outs d%0d", d), 32'(obs(d)), 32'd0);
      check($sformatf("rst illegal d%0d", d), 32'(ill_w[d]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 3; d++)
        check($sformatf("bus_excl d%0d", d),
              32'(($countones(en_w[d][16:12]) <= 1) && !(ren_w[d] && wen_w[d])), 32'd1);
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [6:0] legal [4];
    logic [6:0] op;
    int d;
    int ni;
    legal = '{OP_R, OP_I, OP_L, OP_S};
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      run[k] = 1'b0;
      opc[k] = 7'd0;
    end
    #3;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset outs d%0d", k), 32'(obs(k)), 32'd0);
      check($sformatf("reset illegal d%0d", k), 32'(ill_w[k]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(1, 2);

`ifdef RV_SEQ_PERF_EN
    run[1] = 1'b1;
    exec(1, OP_R, 0, -1);
    exec(1, OP_R, 0, -1);
    exec(1, OP_R, 1, -1);
    idle(1, 1);
    check("retire_cnt", ret_w[1], 32'd3);
    check("cycle_cnt", cyc_w[1], 32'd27);
    check("cycle_cnt idle dut", cyc_w[0], 32'd0);
`endif

    // Directed: one of each class on each latency.
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 4; j++) begin
        run[k] = 1'b1;
        exec(k, legal[j], 1, -1);
        idle(k, 1);
      end
    end

    // Random back-to-back bursts with idle gaps.
    for (int it = 0; it < 40; it++) begin
      d  = $urandom_range(0, 2);
      ni = $urandom_range(1, 4);
      run[d] = 1'b1;
      for (int j = 0; j < ni; j++) begin
        op = legal[$urandom_range(0, 3)];
        exec(d, op, (j == ni - 1), -1);
      end
      idle(d, $urandom_range(1, 3));
    end

    // Reset in L3 of a load (LAT=2: F0 F1 FW F2 F3 DEC L0 L1 L2 L3 -> index 9).
    run[1] = 1'b1;
    exec(1, OP_L, 0, 9);
    check("L3 ram_ren", 32'(ren_w[1]), 32'd1);
    run[1] = 1'b1;
    pulse_reset();
    @(posedge clk); #1;
    check("F0 after reset", 32'(obs(1)), 32'(ov(1, 0, 0, 1, b(16) | b(10))));
    run[1] = 1'b0;
    pulse_reset();

    // Unsupported opcodes lock into ILL until reset.
    run[2] = 1'b1;
    exec(2, 7'b1111111, 0, -1);
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      check($sformatf("ill outs c%0d", c), 32'(obs(2)), 32'd0);
      check($sformatf("ill flag c%0d", c), 32'(ill_w[2]), 32'd1);
    end
    run[0] = 1'b1;
    exec(0, 7'b1100011, 0, -1);
    idle(0, 3);
    check("ill flag branch", 32'(ill_w[0]), 32'd1);
    run[0] = 1'b0;
    run[2] = 1'b0;
    pulse_reset();
    idle(2, 1);
    check("ill cleared", 32'(ill_w[2]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
